// File: rtl/dff_mem_ctrl.sv
// Command-driven initiator for a byte-wide DFF RAM port.
// Accepts write/read/fill/dump commands, drives the RAM strobes, and returns
// read bytes on a valid/ready response channel. Every output is a flop.
module dff_mem_ctrl #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    // command channel
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [ADDR_W-1:0] cmd_len,
    // response channel
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    // status
    output logic              done,
    output logic              busy,
    // RAM port
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rin,
    output logic              mem_rout_n,
    input  logic [DATA_W-1:0] mem_rdata
);

    // cmd_op[1] selects a burst (fill/dump), cmd_op[0] selects the read direction
    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRd,
        StRdWait,
        StRsp
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                mem_rin_q, mem_rin_d;
    logic                mem_rout_n_q, mem_rout_n_d;

    // Next-state sequencing; mem_addr_q/mem_wdata_q double as the burst pointers
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_data_d  = rsp_data_q;
        done_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready_q) begin
                    mem_addr_d  = cmd_addr;
                    mem_wdata_d = cmd_data;
                    cnt_d       = cmd_op[1] ? cmd_len : '0;
                    state_d     = cmd_op[0] ? StRd : StWr;
                end
            end
            StWr: begin
                if (cnt_q != '0) begin
                    mem_addr_d  = mem_addr_q + ADDR_W'(1);
                    mem_wdata_d = mem_wdata_q + DATA_W'(1);
                    cnt_d       = cnt_q - ADDR_W'(1);
                end else begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            StRd: begin
                state_d = StRdWait;
            end
            StRdWait: begin
                // RAM output is registered: valid the cycle after the read strobe
                rsp_data_d = mem_rdata;
                state_d    = StRsp;
            end
            StRsp: begin
                if (rsp_ready) begin
                    if (cnt_q != '0) begin
                        mem_addr_d = mem_addr_q + ADDR_W'(1);
                        cnt_d      = cnt_q - ADDR_W'(1);
                        state_d    = StRd;
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are decoded from the next state so they land registered
        cmd_ready_d  = (state_d == StIdle);
        busy_d       = (state_d != StIdle);
        rsp_valid_d  = (state_d == StRsp);
        mem_rin_d    = (state_d == StRd);
        mem_rout_n_d = (state_d != StWr);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rsp_data_q   <= '0;
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            mem_rin_q    <= 1'b0;
            mem_rout_n_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rsp_data_q   <= rsp_data_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            mem_rin_q    <= mem_rin_d;
            mem_rout_n_q <= mem_rout_n_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_rin    = mem_rin_q;
    assign mem_rout_n = mem_rout_n_q;

endmodule

// File: tb/tb_dff_mem_ctrl.sv
// Bench for dff_mem_ctrl: a byte RAM stand-in, a command-level reference
// model (expected strobe/response queues), directed scenarios and a random phase.
module tb_dff_mem_ctrl;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;
    localparam logic [1:0] OpWr   = 2'b00;
    localparam logic [1:0] OpRd   = 2'b01;
    localparam logic [1:0] OpFill = 2'b10;
    localparam logic [1:0] OpDump = 2'b11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = '0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_data = '0;
    logic [AW-1:0] cmd_len = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_data;
    logic          done;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rin;
    logic          mem_rout_n;
    logic [DW-1:0] ram_dout;

    dff_mem_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .cmd_len    (cmd_len),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .done       (done),
        .busy       (busy),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rin    (mem_rin),
        .mem_rout_n (mem_rout_n),
        .mem_rdata  (ram_dout)
    );

    always #5 clk = ~clk;

    // RAM stand-in: write on rout_n low, registered read on rin high
    logic [DW-1:0] ram [16];
    logic [DW-1:0] model [16];
    logic          load_ram = 1'b1;
    always @(posedge clk) begin
        if (load_ram) begin
            for (int i = 0; i < 16; i++) ram[i] <= model[i];
        end else begin
            if (mem_rout_n === 1'b0) ram[mem_addr] <= mem_wdata;
            if (mem_rin === 1'b1) ram_dout <= ram[mem_addr];
        end
    end

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           wr_q [$];
    logic [AW-1:0] rd_q [$];
    logic [DW-1:0] rsp_q [$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int exp_done = 0;
    int got_done = 0;
    int last_wr_cyc = 0;
    int last_hs_cyc = 0;
    int rsp_idx = 0;
    int rsp_total = 0;
    int wr_cnt = 0;
    int hold_low = 0;
    int stall_idx = -1;
    bit rnd_ready = 1'b0;
    bit gap_chk = 1'b0;
    bit last_is_rd = 1'b0;
    bit accept_done = 1'b0;
    logic          prev_valid = 1'b0;
    logic          prev_hs = 1'b0;
    logic [DW-1:0] prev_data = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance one clock, pick rsp_ready, then check everything visible this cycle
    task automatic step();
        logic hs;
        wr_t  e;
        @(posedge clk);
        cyc++;
        #1;
        if (stall_idx >= 0 && rsp_valid && !prev_valid && rsp_idx == stall_idx) hold_low = 5;
        if (hold_low > 0) begin
            rsp_ready = 1'b0;
            hold_low--;
        end else if (rnd_ready) begin
            rsp_ready = 1'($urandom_range(0, 1));
        end else begin
            rsp_ready = 1'b1;
        end
        hs = rsp_valid && rsp_ready;

        check("strobe_excl", 32'(mem_rin & ~mem_rout_n), 32'd0);
        check("done_rsp_excl", 32'(done & rsp_valid), 32'd0);
        check("ready_busy_excl", 32'(cmd_ready & busy), 32'd0);

        if (!rst && prev_valid && !prev_hs) begin
            check("rsp_hold_valid", 32'(rsp_valid), 32'd1);
            check("rsp_hold_data", 32'(rsp_data), 32'(prev_data));
        end
        if (mem_rout_n === 1'b0) begin
            if (wr_q.size() == 0) begin
                check("wr_unexpected", 32'd1, 32'd0);
            end else begin
                e = wr_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e.a));
                check("wr_data", 32'(mem_wdata), 32'(e.d));
                model[e.a] = e.d;
            end
            last_wr_cyc = cyc;
            wr_cnt++;
        end
        if (mem_rin === 1'b1) begin
            if (rd_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
            else check("rd_addr", 32'(mem_addr), 32'(rd_q.pop_front()));
        end
        if (hs) begin
            if (rsp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
            else check("rsp_data", 32'(rsp_data), 32'(rsp_q.pop_front()));
            if (gap_chk && rsp_idx > 0) check("rsp_gap", 32'(cyc - last_hs_cyc), 32'd3);
            last_hs_cyc = cyc;
            rsp_idx++;
            rsp_total++;
        end
        if (done === 1'b1) begin
            got_done++;
            check("done_lat", 32'(cyc), 32'(last_is_rd ? last_hs_cyc + 1 : last_wr_cyc + 1));
        end
        prev_valid = rsp_valid;
        prev_hs    = hs;
        prev_data  = rsp_data;
    endtask

    // Present a command, wait for the handshake and queue the expected effects
    task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [AW-1:0] len);
        int n;
        int b;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_len   = len;
        cmd_valid = 1'b1;
        b = 0;
        while (cmd_ready !== 1'b1 && b < 300) begin
            step();
            b++;
        end
        if (cmd_ready !== 1'b1) begin
            check("accept_timeout", 32'd0, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        accept_done = done;
        n = op[1] ? int'(len) + 1 : 1;
        for (int i = 0; i < n; i++) begin
            if (!op[0]) wr_q.push_back('{a: AW'((int'(a) + i) % 16), d: DW'((int'(d) + i) % 256)});
            else begin
                rd_q.push_back(AW'((int'(a) + i) % 16));
                rsp_q.push_back(model[(int'(a) + i) % 16]);
            end
        end
        last_is_rd = op[0];
        rsp_idx    = 0;
        wr_cnt     = 0;
        exp_done++;
        step();
        cmd_valid = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
        check("ready_after_accept", 32'(cmd_ready), 32'd0);
    endtask

    task automatic wait_idle();
        int b;
        b = 0;
        while ((got_done != exp_done || wr_q.size() != 0 || rd_q.size() != 0 ||
                rsp_q.size() != 0) && b < 3000) begin
            step();
            b++;
        end
        check("drain_done", 32'(got_done), 32'(exp_done));
        check("drain_queues", 32'(wr_q.size() + rd_q.size() + rsp_q.size()), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_mem_rin"}, 32'(mem_rin), 32'd0);
        check({tag, "_mem_rout_n"}, 32'(mem_rout_n), 32'd1);
    endtask

    initial begin
        int rsp_before;
        for (int i = 0; i < 16; i++) model[i] = DW'($urandom);

        // Reset
        step();
        step();
        check_reset_vals("reset");
        load_ram = 1'b0;
        rst = 1'b0;
        step();
        check("ready_after_reset", 32'(cmd_ready), 32'd1);

        // Single write then single read, with exact latencies
        issue(OpWr, 4'd3, 8'hA5, 4'd9);
        check("wr1_strobe", 32'({mem_rin, mem_rout_n}), 32'd0);
        step();
        check("wr1_done", 32'(done), 32'd1);
        check("wr1_idle", 32'({cmd_ready, busy, mem_rout_n}), 32'b101);
        check("wr1_ram", 32'(ram[3]), 32'hA5);
        issue(OpRd, 4'd3, 8'h00, 4'd7);
        check("rd1_strobe", 32'(mem_rin), 32'd1);
        step();
        check("rd1_wait", 32'({mem_rin, rsp_valid}), 32'd0);
        step();
        check("rd1_valid", 32'(rsp_valid), 32'd1);
        check("rd1_data", 32'(rsp_data), 32'hA5);
        step();
        check("rd1_done", 32'(done), 32'd1);
        wait_idle();

        // Fill wrapping both address and data
        issue(OpFill, 4'd14, 8'hFE, 4'd3);
        wait_idle();
        check("fill_wrap_ram15", 32'(ram[15]), 32'hFF);
        check("fill_wrap_ram0", 32'(ram[0]), 32'h00);

        // Full-depth fill then dump with the response channel always ready
        issue(OpFill, 4'd0, 8'h10, 4'd15);
        wait_idle();
        gap_chk = 1'b1;
        rsp_before = rsp_total;
        issue(OpDump, 4'd0, 8'h00, 4'd15);
        wait_idle();
        gap_chk = 1'b0;
        check("dump16_count", 32'(rsp_total - rsp_before), 32'd16);

        // Backpressure on the second byte of a short dump
        stall_idx = 1;
        rsp_before = rsp_total;
        issue(OpDump, 4'd5, 8'h00, 4'd2);
        wait_idle();
        stall_idx = -1;
        check("dump3_count", 32'(rsp_total - rsp_before), 32'd3);

        // Command held while busy is taken in the done cycle
        issue(OpFill, 4'd8, 8'h30, 4'd4);
        issue(OpWr, 4'd2, 8'h77, 4'd0);
        check("held_accept_in_done", 32'(accept_done), 32'd1);
        wait_idle();

        // Reset after two writes of an eight-byte fill
        issue(OpFill, 4'd1, 8'hC0, 4'd7);
        for (int b = 0; b < 50 && wr_cnt < 2; b++) step();
        rst = 1'b1;
        step();
        check_reset_vals("midrst");
        wr_q.delete();
        exp_done = got_done;
        rst = 1'b0;
        step();
        check("midrst_idle_strobe", 32'(mem_rout_n), 32'd1);
        check("midrst_ready", 32'(cmd_ready), 32'd1);
        check("midrst_ram1", 32'(ram[1]), 32'hC0);
        check("midrst_ram2", 32'(ram[2]), 32'hC1);
        for (int i = 3; i <= 8; i++) check("midrst_ram_untouched", 32'(ram[i]), 32'(model[i]));
        issue(OpWr, 4'd4, 8'h5A, 4'd0);
        wait_idle();
        check("post_rst_write", 32'(ram[4]), 32'h5A);

        // Random commands with random backpressure
        rnd_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            issue(2'($urandom_range(0, 3)), AW'($urandom), DW'($urandom),
                  AW'($urandom_range(0, 15)));
            wait_idle();
        end
        rnd_ready = 1'b0;
        issue(OpDump, 4'd0, 8'h00, 4'd15);
        wait_idle();
        for (int i = 0; i < 16; i++) check("final_ram", 32'(ram[i]), 32'(model[i]));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
